// File: rtl/sb_config_pkg.sv
// Shared types and constants for the tile configuration loader.
// Latency: n/a. Backpressure: n/a.
package sb_config_pkg;

    typedef enum logic [2:0] {
        ST_ADDR,
        ST_DATA,
        ST_CKSUM,
        ST_ISSUE,
        ST_DONE
    } state_t;

    localparam logic [7:0] END_ADDR_DEFAULT = 8'hFF;
    localparam int         FRAME_CNT_W      = 16;

endpackage

// File: rtl/sb_config_byte_assembler.sv
// Collects NB little-endian bytes into one config word; keeps a running XOR when SB_CONFIG_LOADER_CHECKSUM_EN is defined.
// Latency: word_dat/word_complete are combinational views including the byte landing this cycle.
// Backpressure: none; advances only on byte_vld from the loader FSM.
module sb_config_byte_assembler #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_vld,
    input  logic [7:0]            byte_dat,
    output logic [DATA_WIDTH-1:0] word_dat,
    output logic                  word_complete
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]            xor_dat
`endif
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] word_q;

    // Merge the in-flight byte so the loader can capture the full word on the last byte.
    always_comb begin
        word_dat = word_q;
        if (byte_vld) begin
            word_dat[8*int'(cnt_q) +: 8] = byte_dat;
        end
    end

    assign word_complete = byte_vld && (cnt_q == CNT_W'(NB - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clear) begin
            cnt_q  <= '0;
        end else if (byte_vld) begin
            word_q <= word_dat;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
    logic [7:0] xor_q;

    // clear coincides with the address byte, which seeds the checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xor_q <= '0;
        end else if (clear) begin
            xor_q <= byte_dat;
        end else if (byte_vld) begin
            xor_q <= xor_q ^ byte_dat;
        end
    end

    assign xor_dat = xor_q;
`endif

endmodule

// File: rtl/sb_config_loader.sv
// Byte-serial bitstream to config_addr/config_data/config_en write bus; checksum byte enabled by SB_CONFIG_LOADER_CHECKSUM_EN.
// Latency: config_en pulses 1 cycle after the final byte of a record transfers.
// Backpressure: in_ready low during the issue cycle and forever after the end marker; stalls on in_valid low.
module sb_config_loader
    import sb_config_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] END_ADDR   = END_ADDR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ADDR_WIDTH-1:0]  config_addr,
    output logic [DATA_WIDTH-1:0]  config_data,
    output logic                   config_en,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   err
);

    state_t                state_q, state_nxt;
    logic                  xfer;
    logic                  asm_clear;
    logic                  asm_byte_vld;
    logic                  word_complete;
    logic                  ready_nxt;
    logic                  issue_nxt;
    logic [DATA_WIDTH-1:0] asm_word;
    logic [ADDR_WIDTH-1:0] addr_q;
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
    logic [7:0]            asm_xor;
    logic                  cksum_bad;
`endif

    sb_config_byte_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (asm_clear),
        .byte_vld      (asm_byte_vld),
        .byte_dat      (in_data),
        .word_dat      (asm_word),
        .word_complete (word_complete)
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
        ,
        .xor_dat       (asm_xor)
`endif
    );

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_nxt    = state_q;
        asm_clear    = 1'b0;
        asm_byte_vld = 1'b0;
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
        cksum_bad    = 1'b0;
`endif
        case (state_q)
            ST_ADDR: begin
                if (xfer) begin
                    if (in_data == END_ADDR) begin
                        state_nxt = ST_DONE;
                    end else begin
                        asm_clear = 1'b1;
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    asm_byte_vld = 1'b1;
                    if (word_complete) begin
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
                        state_nxt = ST_CKSUM;
`else
                        state_nxt = ST_ISSUE;
`endif
                    end
                end
            end
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
            ST_CKSUM: begin
                if (xfer) begin
                    if (in_data == asm_xor) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        cksum_bad = 1'b1;
                        state_nxt = ST_ADDR;
                    end
                end
            end
`endif
            ST_ISSUE: state_nxt = ST_ADDR;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_ADDR;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    assign ready_nxt = (state_nxt == ST_ADDR) || (state_nxt == ST_DATA) || (state_nxt == ST_CKSUM);
    assign issue_nxt = (state_nxt == ST_ISSUE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ADDR;
            in_ready    <= 1'b0;
            config_en   <= 1'b0;
            config_addr <= '0;
            config_data <= '0;
            done        <= 1'b0;
            frame_count <= '0;
            addr_q      <= '0;
        end else begin
            state_q   <= state_nxt;
            in_ready  <= ready_nxt;
            config_en <= issue_nxt;
            done      <= (state_nxt == ST_DONE);
            if (asm_clear) begin
                addr_q <= in_data[ADDR_WIDTH-1:0];
            end
            if (issue_nxt) begin
                config_addr <= addr_q;
                config_data <= asm_word;
                if (frame_count != '1) begin
                    frame_count <= frame_count + FRAME_CNT_W'(1);
                end
            end
        end
    end

`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (cksum_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed plus randomized records against a record-level expectation queue.
module tb_sb_config_loader;

    localparam int NB     = 4;
    localparam int K_PLAIN = 0;
    localparam int K_FIN   = 1;
    localparam int K_END   = 2;
    localparam int K_BAD   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  config_addr;
    logic [31:0] config_data;
    logic        config_en;
    logic        done;
    logic [15:0] frame_count;
    logic        err;

    int          vectors = 0;
    int          miscompares = 0;

    logic [39:0] exp_q[$];
    logic [15:0] exp_count = 16'd0;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;

    sb_config_loader dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .config_addr (config_addr),
        .config_data (config_data),
        .config_en   (config_en),
        .done        (done),
        .frame_count (frame_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; fin means a good record's last byte transfers at this edge.
    task automatic clock_cycle(input bit fin);
        logic [39:0] rec;
        @(posedge clk);
        @(negedge clk);
        if (fin && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        check("config_en", config_en, fin);
        if (fin && exp_q.size() > 0) begin
            rec = exp_q.pop_front();
            check("config_addr", config_addr, rec[39:32]);
            check("config_data", config_data, rec[31:0]);
            check("in_ready_issue", in_ready, 0);
        end
        check("frame_count", frame_count, exp_count);
        check("done", done, exp_done);
        check("err", err, exp_err);
    endtask

    task automatic put_byte(input logic [7:0] b, input int stall_pct, input int kind);
        int guard = 0;
        bit sent = 0;
        while (!sent) begin
            if (int'($urandom_range(99)) < stall_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
            end
            sent = in_valid && in_ready;
            if (sent && kind == K_END) exp_done = 1'b1;
            if (sent && kind == K_BAD) exp_err = 1'b1;
            clock_cycle(sent && kind == K_FIN);
            guard++;
            if (!sent && guard > 64) begin
                check("xfer_timeout_in_ready", in_ready, 1);
                sent = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_record(input logic [7:0] addr, input logic [31:0] data,
                               input int stall_pct, input bit bad_ck);
        logic [7:0] ck;
        ck = addr;
        if (!bad_ck) exp_q.push_back({addr, data});
        put_byte(addr, stall_pct, K_PLAIN);
        for (int k = 0; k < NB; k++) begin
            ck = ck ^ data[8*k +: 8];
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
            put_byte(data[8*k +: 8], stall_pct, K_PLAIN);
`else
            put_byte(data[8*k +: 8], stall_pct, (k == NB - 1) ? K_FIN : K_PLAIN);
`endif
        end
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
        put_byte(bad_ck ? (ck ^ 8'h5A) : ck, stall_pct, bad_ck ? K_BAD : K_FIN);
`endif
    endtask

    initial begin
        logic [7:0] ra;
        logic [15:0] cnt_before;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_config_en", config_en, 0);
        check("rst_config_addr", config_addr, 0);
        check("rst_config_data", config_data, 0);
        check("rst_done", done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        check("in_ready_at_release", in_ready, 0);
        clock_cycle(0);
        check("in_ready_after_release", in_ready, 1);

        // Back-to-back single record
        send_record(8'h03, 32'h12345678, 0, 0);
        check("frame_count_one", frame_count, 1);

        // Same record with heavy stalls
        send_record(8'h03, 32'h12345678, 50, 0);

        // 0xFF inside data is ordinary data
        send_record(8'h01, 32'hFFFFFFFF, 0, 0);
        check("ff_data_not_done", done, 0);

`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
        cnt_before = frame_count;
        put_byte(8'h03, 0, K_PLAIN);
        put_byte(8'h78, 0, K_PLAIN);
        put_byte(8'h56, 0, K_PLAIN);
        put_byte(8'h34, 0, K_PLAIN);
        put_byte(8'h12, 0, K_PLAIN);
        exp_q.push_back({8'h03, 32'h12345678});
        put_byte(8'h0B, 0, K_FIN);
        check("ck_good_err", err, 0);
        cnt_before = frame_count;
        put_byte(8'h04, 0, K_PLAIN);
        for (int k = 0; k < NB; k++) put_byte(8'h00, 0, K_PLAIN);
        put_byte(8'h00, 0, K_BAD);
        check("ck_bad_err", err, 1);
        check("ck_bad_count", frame_count, cnt_before);
        send_record(8'h07, 32'hCAFEF00D, 20, 0);
`endif

        // Randomized records
        for (int r = 0; r < 40; r++) begin
            ra = 8'($urandom_range(254));
`ifdef SB_CONFIG_LOADER_CHECKSUM_EN
            send_record(ra, $urandom, int'($urandom_range(60)), ($urandom_range(4) == 0));
`else
            send_record(ra, $urandom, int'($urandom_range(60)), 0);
`endif
        end

        // Reset mid-record
        put_byte(8'h05, 0, K_PLAIN);
        put_byte(8'h11, 0, K_PLAIN);
        put_byte(8'h22, 0, K_PLAIN);
        reset = 1'b1;
        #2;
        check("midrst_config_en", config_en, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_frame_count", frame_count, 0);
        exp_count = 16'd0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clock_cycle(0);
        check("in_ready_after_midrst", in_ready, 1);
        send_record(8'h02, 32'hDDCCBBAA, 0, 0);
        check("frame_count_after_midrst", frame_count, 1);

        // End marker, then a held byte must be ignored
        put_byte(8'hFF, 0, K_END);
        check("done_set", done, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h05;
            check("done_in_ready", in_ready, 0);
            clock_cycle(0);
        end
        in_valid = 1'b0;
        check("done_frame_count", frame_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
